seq_pattern_gen: RTL and testbench

//  Stimulus stage driving x/y/z into the sequence-assertion checker.
//  On a start request it emits one pattern of the form x ##DELAY1 y[*rep] ##DELAY2 z.
//  The repetition count rep is programmable in [MIN_REP:MAX_REP].

---
 rtl/seq_gen_pkg.sv | 34 +++
 rtl/seq_gen_cnt.sv | 36 +++
 rtl/seq_pattern_gen.sv | 185 ++++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// Purpose: shared types and helpers for the x/y/z sequence pattern generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package seq_gen_pkg;

    // Pattern phases. Each phase drives at most one of x/y/z.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        X    = 3'd1,
        GAP1 = 3'd2,
        Y    = 3'd3,
        GAP2 = 3'd4,
        Z    = 3'd5
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Width of the shared phase counter: it has to hold the longest phase length.
    function automatic int cnt_w(input int d1, input int d2, input int max_rep);
        return $clog2(max3(d1, d2, max_rep) + 1);
    endfunction

    // Out-of-range repetition requests are clamped rather than rejected.
    function automatic int clamp_rep(input int v, input int min_rep, input int max_rep);
        if (v < min_rep) return min_rep;
        if (v > max_rep) return max_rep;
        return v;
    endfunction

endpackage

// File: rtl/seq_gen_cnt.sv
// Purpose: loadable down-counter timing each pattern phase; flags count==1.
// Latency: load_val visible on count one cycle after load; one is combinational from count.
// Backpressure: none; load has priority over dec, and the count holds at zero (no wrap).
//
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   load        load load_val this cycle
//   load_val    value loaded on phase entry
//   dec         decrement (ignored while loading or at zero)
//   one         high when the count is exactly 1, i.e. the last cycle of the phase
module seq_gen_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         one
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign one = (count == W'(1));

endmodule

// File: rtl/seq_pattern_gen.sv
// Purpose: on an accepted start, emit one x ##DELAY1 y[*rep] ##DELAY2 z pattern.
// Latency: x one cycle after accept, z at x+DELAY1+rep-1+DELAY2, done coincident with z.
// Backpressure: start is taken only when ready (IDLE or Z); otherwise it is dropped, not queued.
//
// Ports:
//   clk, rst_n  clock and synchronous active-low reset (abandons any pattern in flight)
//   err_inj     only when SEQ_GEN_ERR_INJECT_EN is defined: suppress z of this pattern
//   start       pattern request
//   rep_len     y repetition count, clamped to [MIN_REP:MAX_REP] and latched on accept
//   ready       a start is accepted this cycle
//   x, y, z     registered stimulus outputs
//   done        one-cycle pulse in the z cycle
//
// Optional feature macro: SEQ_GEN_ERR_INJECT_EN
module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int DELAY1  = 2,
    parameter int DELAY2  = 1,
    parameter int MIN_REP = 3,
    parameter int MAX_REP = 4,
    parameter int REP_W   = $clog2(MAX_REP + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef SEQ_GEN_ERR_INJECT_EN
    input  logic             err_inj,
`endif
    input  logic             start,
    input  logic [REP_W-1:0] rep_len,
    output logic             ready,
    output logic             x,
    output logic             y,
    output logic             z,
    output logic             done
);

    if (DELAY1 < 1) begin : g_bad_delay1
        $error("seq_pattern_gen: DELAY1 must be >= 1");
    end
    if (DELAY2 < 1) begin : g_bad_delay2
        $error("seq_pattern_gen: DELAY2 must be >= 1");
    end
    if (MIN_REP < 1) begin : g_bad_min_rep
        $error("seq_pattern_gen: MIN_REP must be >= 1");
    end
    if (MAX_REP < MIN_REP) begin : g_bad_max_rep
        $error("seq_pattern_gen: MAX_REP must be >= MIN_REP");
    end

    localparam int CW = cnt_w(DELAY1, DELAY2, MAX_REP);

    // Gap phases hold one cycle less than their delay: the x / last-y cycle supplies the other.
    localparam logic [CW-1:0] GAP1_LEN = CW'(DELAY1 - 1);
    localparam logic [CW-1:0] GAP2_LEN = CW'(DELAY2 - 1);
    localparam logic [CW-1:0] ONE_LEN  = CW'(1);

    state_e          state;
    state_e          nxt;
    logic [CW-1:0]   rep_q;
    logic [CW-1:0]   rep_clamped;
    logic            accept;
    logic            cnt_load;
    logic [CW-1:0]   cnt_val;
    logic            cnt_one;
`ifdef SEQ_GEN_ERR_INJECT_EN
    logic            err_q;
`endif

    assign ready       = (state == IDLE) || (state == Z);
    assign accept      = start && ready;
    assign rep_clamped = CW'(clamp_rep(int'(rep_len), MIN_REP, MAX_REP));

    // Next phase plus a counter load on every phase entry; each timed phase
    // leaves on the cycle its counter reads 1.
    always_comb begin
        nxt      = state;
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    nxt      = X;
                    cnt_load = 1'b1;
                    cnt_val  = ONE_LEN;
                end
            end
            X: begin
                cnt_load = 1'b1;
                if (DELAY1 > 1) begin
                    nxt     = GAP1;
                    cnt_val = GAP1_LEN;
                end else begin
                    nxt     = Y;
                    cnt_val = rep_q;
                end
            end
            GAP1: begin
                if (cnt_one) begin
                    nxt      = Y;
                    cnt_load = 1'b1;
                    cnt_val  = rep_q;
                end
            end
            Y: begin
                if (cnt_one) begin
                    cnt_load = 1'b1;
                    if (DELAY2 > 1) begin
                        nxt     = GAP2;
                        cnt_val = GAP2_LEN;
                    end else begin
                        nxt     = Z;
                        cnt_val = ONE_LEN;
                    end
                end
            end
            GAP2: begin
                if (cnt_one) begin
                    nxt      = Z;
                    cnt_load = 1'b1;
                    cnt_val  = ONE_LEN;
                end
            end
            Z: begin
                cnt_load = 1'b1;
                if (start) begin
                    nxt     = X;
                    cnt_val = ONE_LEN;
                end else begin
                    nxt     = IDLE;
                    cnt_val = '0;
                end
            end
            default: begin
                nxt      = IDLE;
                cnt_load = 1'b1;
                cnt_val  = '0;
            end
        endcase
    end

    seq_gen_cnt #(
        .W (CW)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (!cnt_load),
        .one      (cnt_one)
    );

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            x     <= 1'b0;
            y     <= 1'b0;
            z     <= 1'b0;
            done  <= 1'b0;
            rep_q <= CW'(MIN_REP);
`ifdef SEQ_GEN_ERR_INJECT_EN
            err_q <= 1'b0;
`endif
        end else begin
            state <= nxt;
            x     <= (nxt == X);
            y     <= (nxt == Y);
            done  <= (nxt == Z);
`ifdef SEQ_GEN_ERR_INJECT_EN
            // Suppressed z is the deliberate violation; done still marks the slot.
            z     <= (nxt == Z) && !err_q;
`else
            z     <= (nxt == Z);
`endif
            if (accept) begin
                rep_q <= rep_clamped;
`ifdef SEQ_GEN_ERR_INJECT_EN
                err_q <= err_inj;
`endif
            end
        end
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Purpose: self-checking bench for seq_pattern_gen using a pattern-timeline scoreboard.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_seq_pattern_gen;

    localparam int D1   = 2;
    localparam int D2   = 1;
    localparam int MINR = 3;
    localparam int MAXR = 4;
    localparam int RW   = $clog2(MAXR + 1);
`ifdef SEQ_GEN_ERR_INJECT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        int xc;
        int rep;
        bit err;
    } pat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [RW-1:0] rep_len = '0;
    logic          ready, x, y, z, done;
`ifdef SEQ_GEN_ERR_INJECT_EN
    logic          err_inj = 1'b0;
`endif

    pat_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   z_cnt = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    seq_pattern_gen #(
        .DELAY1  (D1),
        .DELAY2  (D2),
        .MIN_REP (MINR),
        .MAX_REP (MAXR)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef SEQ_GEN_ERR_INJECT_EN
        .err_inj (err_inj),
`endif
        .start   (start),
        .rep_len (rep_len),
        .ready   (ready),
        .x       (x),
        .y       (y),
        .z       (z),
        .done    (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    function automatic int zc_of(input pat_t p);
        return p.xc + D1 + p.rep - 1 + D2;
    endfunction

    function automatic bit busy(input int n);
        foreach (q[i]) if (q[i].xc <= n && n < zc_of(q[i])) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int clamp(input int v);
        if (v < MINR) return MINR;
        if (v > MAXR) return MAXR;
        return v;
    endfunction

    // Drive one cycle of inputs, predict, advance one clock, compare at negedge.
    task automatic cycle(input bit st, input int rl, input bit ei, input bit rn);
        pat_t p;
        bit ex, ey, ez, ed;
        start   = st;
        rep_len = RW'(rl);
        rst_n   = rn;
`ifdef SEQ_GEN_ERR_INJECT_EN
        err_inj = ei;
`endif
        if (!rn) begin
            q.delete();
        end else if (st && !busy(cyc)) begin
            p.xc  = cyc + 1;
            p.rep = clamp(rl);
            p.err = ei;
            q.push_back(p);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        while (q.size() > 0 && zc_of(q[0]) < cyc) void'(q.pop_front());
        ex = 0; ey = 0; ez = 0; ed = 0;
        foreach (q[i]) begin
            ex |= (q[i].xc == cyc);
            ey |= (cyc >= q[i].xc + D1) && (cyc <= q[i].xc + D1 + q[i].rep - 1);
            ed |= (zc_of(q[i]) == cyc);
            ez |= (zc_of(q[i]) == cyc) && !q[i].err;
        end
        chk($sformatf("xyzdr@%0d", cyc), 32'({x, y, z, done, ready}),
            32'({ex, ey, ez, ed, !busy(cyc)}));
        z_cnt    += int'(z);
        done_cnt += int'(done);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 1'b1);
    endtask

    initial begin
        int zb, db;
        // Reset state.
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b0, 1'b0);

        // Basic pattern, rep_len=3.
        zb = z_cnt;
        cycle(1'b1, 3, 1'b0, 1'b1);
        idle(8);
        chk("t1_zcount", 32'(z_cnt - zb), 32'd1);

        // Clamping below and above.
        cycle(1'b1, 0, 1'b0, 1'b1);
        idle(8);
        cycle(1'b1, 7, 1'b0, 1'b1);
        idle(9);

        // Start held high: back-to-back patterns.
        zb = z_cnt;
        for (int i = 0; i < 28; i++) cycle(1'b1, 4, 1'b0, 1'b1);
        idle(10);
        chk("t3_zcount", 32'(z_cnt - zb), 32'd4);

        // Starts while busy are dropped.
        zb = z_cnt;
        cycle(1'b1, 3, 1'b0, 1'b1);
        cycle(1'b1, 4, 1'b0, 1'b1);
        cycle(1'b0, 0, 1'b0, 1'b1);
        cycle(1'b1, 4, 1'b0, 1'b1);
        cycle(1'b1, 4, 1'b0, 1'b1);
        idle(8);
        chk("t4_zcount", 32'(z_cnt - zb), 32'd1);

        // Reset during Y abandons the pattern.
        zb = z_cnt;
        cycle(1'b1, 4, 1'b0, 1'b1);
        cycle(1'b0, 0, 1'b0, 1'b1);
        cycle(1'b0, 0, 1'b0, 1'b1);
        cycle(1'b0, 0, 1'b0, 1'b0);
        idle(6);
        chk("t5_zcount_abandoned", 32'(z_cnt - zb), 32'd0);
        cycle(1'b1, 3, 1'b0, 1'b1);
        idle(8);
        chk("t5_zcount_after", 32'(z_cnt - zb), 32'd1);

`ifdef SEQ_GEN_ERR_INJECT_EN
        // Error injection: z suppressed, done still pulses.
        zb = z_cnt;
        db = done_cnt;
        cycle(1'b1, 3, 1'b1, 1'b1);
        idle(8);
        chk("t6_zcount", 32'(z_cnt - zb), 32'd0);
        chk("t6_donecount", 32'(done_cnt - db), 32'd1);
`endif

        // Random traffic.
        zb = z_cnt;
        db = done_cnt;
        for (int i = 0; i < 300; i++)
            cycle(($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)),
                  ERR_EN & 1'($urandom_range(0, 1)), 1'b1);
        idle(12);
        if (!ERR_EN) chk("rand_z_eq_done", 32'(z_cnt - zb), 32'(done_cnt - db));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
